// File: rtl/hilo_mdu_ctrl.sv
// HI/LO register pair with fixed-latency multiply/divide sequencer for the MIPS pipeline.
// Starts ops from E, stalls hilo users in D while busy, and serves MFHI/MFLO reads.
module hilo_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_rdata1,
  input  logic [31:0] in_rdata2,
  input  logic        in_d_use_hilo,
  output logic        out_start,
  output logic        out_busy,
  output logic        out_stall,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo,
  output logic [31:0] out_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  state_t      state, state_d;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;
  logic        is_md;

  logic [63:0] prod;
  logic [31:0] quo, rem, b_safe;

  assign is_md = (in_op >= OP_MULT) && (in_op <= OP_DIVU);

  always_comb begin
    state_d   = state;
    out_start = 1'b0;
    case (state)
      IDLE: if (is_md) begin
        out_start = 1'b1;
        state_d   = BUSY;
      end
      BUSY: if (cnt == 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divisor forced to 1 when zero so the datapath never evaluates x/0; the
  // write-back is suppressed for that case anyway.
  always_comb begin
    b_safe = (b_q == '0) ? 32'd1 : b_q;
    prod   = '0;
    quo    = '0;
    rem    = '0;
    case (op_q)
      OP_MULT:  prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      OP_MULTU: prod = {32'd0, a_q} * {32'd0, b_q};
      OP_DIV: begin
        quo = $signed(a_q) / $signed(b_safe);
        rem = $signed(a_q) % $signed(b_safe);
      end
      OP_DIVU: begin
        quo = a_q / b_safe;
        rem = a_q % b_safe;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (out_start) begin
            op_q <= in_op;
            a_q  <= in_rdata1;
            b_q  <= in_rdata2;
            cnt  <= (in_op <= OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          end else if (in_op == OP_MTHI) begin
            hi_q <= in_rdata1;
          end else if (in_op == OP_MTLO) begin
            lo_q <= in_rdata1;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (op_q == OP_MULT || op_q == OP_MULTU) begin
              hi_q <= prod[63:32];
              lo_q <= prod[31:0];
            end else if (b_q != '0) begin
              hi_q <= rem;
              lo_q <= quo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_busy  = (state == BUSY);
  assign out_stall = in_d_use_hilo && (out_start || out_busy);
  assign out_hi    = hi_q;
  assign out_lo    = lo_q;

  always_comb begin
    out_rdata = '0;
    if (in_op == OP_MFHI)      out_rdata = hi_q;
    else if (in_op == OP_MFLO) out_rdata = lo_q;
  end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Self-checking bench for hilo_mdu_ctrl: cycle model compared every cycle plus
// directed literal expectations for the main multiply/divide/move scenarios.
module tb_hilo_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_op;
  logic [31:0] in_rdata1, in_rdata2;
  logic        in_d_use_hilo;
  logic        out_start, out_busy, out_stall;
  logic [31:0] out_hi, out_lo, out_rdata;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  hilo_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .in_op(in_op),
    .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
    .in_d_use_hilo(in_d_use_hilo),
    .out_start(out_start), .out_busy(out_busy), .out_stall(out_stall),
    .out_hi(out_hi), .out_lo(out_lo), .out_rdata(out_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi = '0, m_lo = '0;
  int          m_busy = 0;
  logic [63:0] p_res = '0;
  bit          p_wr = 1'b0;
  logic [63:0] r_res;
  bit          r_wr;

  function automatic void model_result(input logic [3:0] op, input logic [31:0] a, b,
                                       output logic [63:0] res, output bit wr);
    longint la, lb, ma, mb, mq, mr, q, r;
    res = '0;
    wr  = 1'b1;
    la  = longint'($signed(a));
    lb  = longint'($signed(b));
    case (op)
      4'd1: res = 64'(la * lb);
      4'd2: res = {32'd0, a} * {32'd0, b};
      4'd3, 4'd4: begin
        if (b == 0) wr = 1'b0;
        else if (op == 4'd3) begin
          ma = (la < 0) ? -la : la;
          mb = (lb < 0) ? -lb : lb;
          mq = ma / mb;
          mr = ma - mq * mb;
          q  = ((la < 0) != (lb < 0)) ? -mq : mq;
          r  = (la < 0) ? -mr : mr;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {32'(a % b), 32'(a / b)};
        end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  always_comb model_result(in_op, in_rdata1, in_rdata2, r_res, r_wr);

  always @(posedge clk) begin
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 0; p_wr <= 1'b0; p_res <= '0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1 && p_wr) begin
        m_hi <= p_res[63:32];
        m_lo <= p_res[31:0];
      end
    end else if (in_op >= 4'd1 && in_op <= 4'd4) begin
      m_busy <= (in_op <= 4'd2) ? MC : DC;
      p_res  <= r_res;
      p_wr   <= r_wr;
    end else if (in_op == 4'd5) begin
      m_hi <= in_rdata1;
    end else if (in_op == 4'd6) begin
      m_lo <= in_rdata1;
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_start, e_busy;
      logic [31:0] e_rd;
      e_start = (m_busy == 0) && (in_op >= 4'd1) && (in_op <= 4'd4);
      e_busy  = (m_busy > 0);
      e_rd    = (in_op == 4'd7) ? m_hi : (in_op == 4'd8) ? m_lo : 32'd0;
      check32("model_start", 32'(out_start), 32'(e_start));
      check32("model_busy",  32'(out_busy),  32'(e_busy));
      check32("model_stall", 32'(out_stall), 32'(in_d_use_hilo && (e_start || e_busy)));
      check32("model_hi",    out_hi, m_hi);
      check32("model_lo",    out_lo, m_lo);
      check32("model_rdata", out_rdata, e_rd);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [3:0] op, input logic [31:0] a, b, input logic d);
    in_op = op; in_rdata1 = a; in_rdata2 = b; in_d_use_hilo = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, b, input logic d,
                        output int nb, output int ns);
    nb = 0; ns = 0;
    drive(op, a, b, d);
    @(negedge clk);
    if (out_busy) nb++;
    if (out_stall) ns++;
    tick();
    drive(4'd0, 32'd0, 32'd0, d);
    repeat (15) begin
      @(negedge clk);
      if (out_busy) nb++;
      if (out_stall) ns++;
    end
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int nb, ns;
    reset = 1'b1;
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check32("reset_busy", 32'(out_busy), 32'd0);
    check32("reset_hi", out_hi, 32'd0);
    check32("reset_lo", out_lo, 32'd0);

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, nb, ns);
    check32("mult_busy_cycles", 32'(nb), 32'd5);
    check32("mult_hi", out_hi, 32'hFFFF_FFFF);
    check32("mult_lo", out_lo, 32'hFFFF_FFFA);

    run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, nb, ns);
    check32("multu_hi", out_hi, 32'h0000_0002);
    check32("multu_lo", out_lo, 32'hFFFF_FFFA);
    drive(4'd7, 32'd0, 32'd0, 1'b0); #1;
    check32("mfhi", out_rdata, 32'h0000_0002);
    drive(4'd8, 32'd0, 32'd0, 1'b0); #1;
    check32("mflo", out_rdata, 32'hFFFF_FFFA);
    tick();

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, nb, ns);
    check32("div_busy_cycles", 32'(nb), 32'd10);
    check32("div_stall_cycles", 32'(ns), 32'd11);
    check32("div_lo", out_lo, 32'hFFFF_FFFD);
    check32("div_hi", out_hi, 32'hFFFF_FFFF);

    run_op(4'd4, 32'd7, 32'd2, 1'b0, nb, ns);
    check32("divu_nostall", 32'(ns), 32'd0);
    check32("divu_lo", out_lo, 32'd3);
    check32("divu_hi", out_hi, 32'd1);

    drive(4'd5, 32'd0, 32'd0, 1'b0); tick();
    drive(4'd6, 32'h1234_5678, 32'd0, 1'b0); tick();
    check32("mtlo_visible", out_lo, 32'h1234_5678);
    drive(4'd8, 32'd0, 32'd0, 1'b0); #1;
    check32("mflo_after_mtlo", out_rdata, 32'h1234_5678);
    run_op(4'd3, 32'd5, 32'd0, 1'b0, nb, ns);
    check32("div0_busy_cycles", 32'(nb), 32'd10);
    check32("div0_lo", out_lo, 32'h1234_5678);
    check32("div0_hi", out_hi, 32'd0);

    // back-to-back start, plus an MTHI while busy that must be ignored
    drive(4'd1, 32'd6, 32'd7, 1'b0); tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    repeat (5) tick();
    drive(4'd4, 32'd100, 32'd7, 1'b0); #1;
    check32("b2b_start", 32'(out_start), 32'd1);
    check32("b2b_mult_lo", out_lo, 32'd42);
    tick();
    drive(4'd5, 32'h0000_DEAD, 32'd0, 1'b0); tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    repeat (10) tick();
    check32("b2b_divu_lo", out_lo, 32'd14);
    check32("b2b_divu_hi", out_hi, 32'd2);

    drive(4'd1, 32'd3, 32'd3, 1'b0); tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0); tick();
    tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    check32("midreset_busy", 32'(out_busy), 32'd0);
    check32("midreset_hi", out_hi, 32'd0);
    check32("midreset_lo", out_lo, 32'd0);
    run_op(4'd1, 32'd4, 32'd5, 1'b0, nb, ns);
    check32("post_reset_mult_lo", out_lo, 32'd20);
    check32("post_reset_mult_busy", 32'(nb), 32'd5);

    reset = 1'b1;
    drive(4'd1, 32'd2, 32'd2, 1'b0); tick();
    reset = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    check32("reset_start_busy", 32'(out_busy), 32'd0);
    check32("reset_start_lo", out_lo, 32'd0);
    repeat (6) tick();
    check32("reset_start_no_result", out_lo, 32'd0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
